// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath types, FSM encoding and GF(2^8) helpers
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Coefficient index j = (source row - output row) mod 4.
    localparam logic [1:0] COEF_J0 = 2'd0;
    localparam logic [1:0] COEF_J1 = 2'd1;
    localparam logic [1:0] COEF_J2 = 2'd2;
    localparam logic [1:0] COEF_J3 = 2'd3;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/gfmul_inv.sv
// rtl/gfmul_inv.sv - constant GF(2^8) multiples of one byte for (Inv)MixColumns
module gfmul_inv
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] x2,
    output logic [7:0] x3,
    output logic [7:0] x9,
    output logic [7:0] xb,
    output logic [7:0] xd,
    output logic [7:0] xe
);

    logic [7:0] x4;
    logic [7:0] x8;

    always_comb begin
        x2 = xtime(din);
        x4 = xtime(x2);
        x8 = xtime(x4);
        x3 = x2 ^ din;
        x9 = x8 ^ din;
        xb = x8 ^ x2 ^ din;
        xd = x8 ^ x4 ^ din;
        xe = x8 ^ x4 ^ x2;
    end

endmodule

// File: rtl/inv_mixcol_seq.sv
// rtl/inv_mixcol_seq.sv - byte-serial InvMixColumns engine; INV_MIXCOL_FWD_EN adds forward mode
module inv_mixcol_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         fwd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    fsm_t            state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    state_t          src_q, src_d;
    state_t          result_q, result_d;
    logic [0:3][7:0] acc_q, acc_d;
    logic            out_valid_q, out_valid_d;
    logic [0:3][7:0] prod_row;

    logic [7:0] cur_byte;
    logic [7:0] m2, m3, m9, mb, md, me;

`ifdef INV_MIXCOL_FWD_EN
    logic fwd_q, fwd_d;
`else
    logic unused_fwd_terms;
    assign unused_fwd_terms = ^{fwd, m2, m3};
`endif

    // Source register shifts left each RUN cycle, so the active byte is always the top one.
    assign cur_byte = src_q[127:120];

    gfmul_inv u_gfmul (
        .din (cur_byte),
        .x2  (m2),
        .x3  (m3),
        .x9  (m9),
        .xb  (mb),
        .xd  (md),
        .xe  (me)
    );

    function automatic byte_t inv_coef(input logic [1:0] j, input byte_t p9, input byte_t pb,
                                       input byte_t pd, input byte_t pe);
        case (j)
            COEF_J0: return pe;
            COEF_J1: return pb;
            COEF_J2: return pd;
            default: return p9;
        endcase
    endfunction

`ifdef INV_MIXCOL_FWD_EN
    function automatic byte_t fwd_coef(input logic [1:0] j, input byte_t p1, input byte_t p2,
                                       input byte_t p3);
        case (j)
            COEF_J0: return p2;
            COEF_J1: return p3;
            default: return p1;
        endcase
    endfunction
`endif

    always_comb begin
        prod_row = '0;
        for (int r = 0; r < 4; r++) begin
`ifdef INV_MIXCOL_FWD_EN
            prod_row[r] = fwd_q ? fwd_coef(cnt_q[1:0] - 2'(r), cur_byte, m2, m3)
                                : inv_coef(cnt_q[1:0] - 2'(r), m9, mb, md, me);
`else
            prod_row[r] = inv_coef(cnt_q[1:0] - 2'(r), m9, mb, md, me);
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
`ifdef INV_MIXCOL_FWD_EN
        fwd_d       = fwd_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d   = in_data;
                    cnt_d   = 4'd0;
                    acc_d   = '0;
                    state_d = RUN;
`ifdef INV_MIXCOL_FWD_EN
                    fwd_d   = fwd;
`endif
                end
            end
            RUN: begin
                src_d = {src_q[119:0], 8'h00};
                cnt_d = cnt_q + 4'd1;
                // Last row of a column: fold the final product straight into the result.
                if (cnt_q[1:0] == 2'd3) begin
                    for (int c = 0; c < 4; c++) begin
                        if (cnt_q[3:2] == 2'(c)) begin
                            result_d[127 - 32*c -: 32] = acc_q ^ prod_row;
                        end
                    end
                    acc_d = '0;
                end else begin
                    acc_d = acc_q ^ prod_row;
                end
                if (cnt_q == 4'd15) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            src_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef INV_MIXCOL_FWD_EN
            fwd_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
`ifdef INV_MIXCOL_FWD_EN
            fwd_q       <= fwd_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = result_q;

endmodule

// File: tb/tb_inv_mixcol_seq.sv
// tb/tb_inv_mixcol_seq.sv - scoreboard bench for inv_mixcol_seq (honours INV_MIXCOL_FWD_EN)
module tb_inv_mixcol_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         fwd = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];

`ifdef INV_MIXCOL_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    inv_mixcol_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .fwd       (fwd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic f);
        logic [7:0]   coef [4];
        logic [127:0] o = '0;
        logic [7:0]   a;
        if (f) begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end else begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a = 8'h00;
                for (int i = 0; i < 4; i++)
                    a = a ^ gmul(s[127 - 32*c - 8*i -: 8], coef[(i - r + 4) % 4]);
                o[127 - 32*c - 8*r -: 8] = a;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Presents one block and returns once it is accepted (sample point #1 after accept edge).
    task automatic accept(input logic [127:0] d, input logic f, output bit timeout);
        in_data  = d;
        fwd      = f;
        in_valid = 1'b1;
        timeout  = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (in_ready) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rand128();
        fwd      = ~f;
    endtask

    task automatic wait_out(input int max, output int lat, output bit timeout);
        lat = 0;
        timeout = 1'b1;
        for (int k = 1; k <= max; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_inverse_fips();
        bit to;
        int lat;
        logic [127:0] exp;
        exp_q.push_back(128'hdb135345_f20a225c_01010101_c6c6c6c6);
        accept(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL inv_accept timeout got=1 exp=0"); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL inv_busy got=%b/%b exp=1/0", busy, in_ready); end
        wait_out(40, lat, to);
        checks++; if (to || lat != 16) begin failures++; $display("FAIL inv_latency got=%0d exp=16 (timeout=%0d)", lat, to); end
        exp = exp_q.pop_front();
        checks++; if (out_data !== exp) begin failures++; $display("FAIL inv_fips_data got=%h exp=%h", out_data, exp); end
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL inv_release got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_forward();
        bit to;
        int lat;
        logic [127:0] d, exp;
        d = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
`ifdef INV_MIXCOL_FWD_EN
        exp_q.push_back(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8);
`else
        exp_q.push_back(ref_mix(d, 1'b0));
`endif
        accept(d, 1'b1, to);
        wait_out(40, lat, to);
        exp = exp_q.pop_front();
        checks++; if (to || out_data !== exp) begin failures++; $display("FAIL fwd_fips_data got=%h exp=%h (timeout=%0d)", out_data, exp, to); end
        consume();
        for (int n = 0; n < 3; n++) begin
            d = rand128();
            exp_q.push_back(ref_mix(d, FWD_EN));
            accept(d, 1'b1, to);
            wait_out(40, lat, to);
            exp = exp_q.pop_front();
            checks++; if (to || out_data !== exp) begin failures++; $display("FAIL fwd_rand_data%0d got=%h exp=%h", n, out_data, exp); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int lat;
        logic [127:0] a, b, exp_a, exp_b;
        bit stable_ok;
        a = rand128();
        b = rand128();
        exp_q.push_back(ref_mix(a, 1'b0));
        accept(a, 1'b0, to);
        wait_out(40, lat, to);
        exp_a = exp_q.pop_front();
        checks++; if (to || out_data !== exp_a) begin failures++; $display("FAIL bp_first_data got=%h exp=%h", out_data, exp_a); end
        in_data = b; fwd = 1'b0; in_valid = 1'b1;
        stable_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_a || in_ready !== 1'b0) begin
                failures++; stable_ok = 1'b0;
                $display("FAIL bp_hold cyc%0d got=%b/%h/%b exp=1/%h/0", k, out_valid, out_data, in_ready, exp_a);
            end
        end
        exp_q.push_back(ref_mix(b, 1'b0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b/%b exp=1/0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rand128();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_second_accept got=%b exp=1", busy); end
        wait_out(40, lat, to);
        exp_b = exp_q.pop_front();
        checks++; if (to || lat != 16 || out_data !== exp_b) begin failures++; $display("FAIL bp_second_data got=%h exp=%h lat=%0d", out_data, exp_b, lat); end
        consume();
    endtask

    task automatic test_back_to_back();
        int cyc, n_acc, n_out, busy_low;
        int acc_cyc [2];
        logic [127:0] a, b, exp;
        a = rand128();
        b = rand128();
        cyc = 0; n_acc = 0; n_out = 0; busy_low = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        in_data = a; fwd = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        while (n_out < 2 && cyc < 120) begin
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected_out got=%h exp=none", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", n_out, out_data, exp); end
                end
                n_out++;
            end
            if (n_acc == 1 && !busy) busy_low++;
            if (in_valid && in_ready) begin
                acc_cyc[n_acc] = cyc;
                exp_q.push_back(ref_mix(in_data, 1'b0));
                n_acc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (n_acc == 1) in_data = b;
            if (n_acc == 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (n_out != 2) begin failures++; $display("FAIL b2b_timeout got=%0d exp=2 outputs", n_out); end
        checks++; if (acc_cyc[1] - acc_cyc[0] != 18) begin failures++; $display("FAIL b2b_spacing got=%0d exp=18", acc_cyc[1] - acc_cyc[0]); end
        checks++; if (busy_low != 1) begin failures++; $display("FAIL b2b_busy_gap got=%0d exp=1", busy_low); end
    endtask

    task automatic test_reset_mid_run();
        bit to;
        int lat;
        logic [127:0] exp;
        accept(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0, to);
        repeat (7) @(posedge clk);
        #1;
        checks++; if (out_data === 128'h0) begin failures++; $display("FAIL midrun_partial got=%h exp=nonzero column0", out_data); end
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrun_reset_state got=%b/%b exp=1/0", in_ready, busy); end
        checks++; if (out_valid !== 1'b0 || out_data !== 128'h0) begin failures++; $display("FAIL midrun_reset_out got=%b/%h exp=0/0", out_valid, out_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(128'h0);
        accept(128'h0, 1'b0, to);
        wait_out(40, lat, to);
        exp = exp_q.pop_front();
        checks++; if (to || out_data !== exp) begin failures++; $display("FAIL midrun_fresh_data got=%h exp=%h", out_data, exp); end
        consume();
    endtask

    initial begin
        test_reset();
        test_inverse_fips();
        test_forward();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
